// File: rtl/collision_flag_bank.sv
// collision_flag_bank
//   Merges 2-bit collision codes for N_MOBILE mobile sprites over one analysis
//   pass. At the end of the pass the codes are copied to a held output copy,
//   together with a saturating per-frame collision count. The bank also raises
//   a maskable level interrupt, which irq_ack clears.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for frame_start (direct or pending from COMMIT)
//   ACCUM  | merging comparison results into the accumulator
//   COMMIT | one cycle: copy accumulator/count to outputs, evaluate irq
//
// Ports:
//   clk, reset                   clock, async active-low reset
//   frame_start, frame_done      pass begin / pass end pulses
//   update_valid, collision_result, number_of_mobile_sprite,
//   number_of_comparison_sprite  one comparison result per cycle
//   irq_mask, irq_ack            interrupt enable per sprite, clear pulse
//   collision_flags, flags_valid, collision_count, frame_aborted
//                                committed results and status
//   busy, irq                    in-pass indicator, level interrupt
module collision_flag_bank #(
  parameter int N_MOBILE    = 15,
  parameter int SPRITE_BITS = 5,
  parameter int FIXED_BEGIN = 15,
  parameter int COUNT_BITS  = 8,
  parameter int IGNORE_SELF = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     frame_done,
  input  logic                     update_valid,
  input  logic                     collision_result,
  input  logic [SPRITE_BITS-1:0]   number_of_mobile_sprite,
  input  logic [SPRITE_BITS-1:0]   number_of_comparison_sprite,
  input  logic [N_MOBILE-1:0]      irq_mask,
  input  logic                     irq_ack,
  output logic [2*N_MOBILE-1:0]    collision_flags,
  output logic                     flags_valid,
  output logic [COUNT_BITS-1:0]    collision_count,
  output logic                     frame_aborted,
  output logic                     busy,
  output logic                     irq
);

  typedef enum logic [1:0] {IDLE, ACCUM, COMMIT} state_t;

  state_t                  state, state_next;
  logic [2*N_MOBILE-1:0]   acc, acc_next;
  logic [COUNT_BITS-1:0]   cnt, cnt_next;
  logic                    start_pending;

  logic                    clear_acc;
  logic                    accum_en;
  logic                    restart;
  logic                    commit;
  logic                    hit;
  logic [1:0]              cls;
  logic                    irq_set;

  // Event qualification: only real collisions of a valid mobile sprite count,
  // optionally excluding a sprite compared against itself.
  always_comb begin
    hit = update_valid && collision_result
          && (int'(number_of_mobile_sprite) < N_MOBILE)
          && !((IGNORE_SELF != 0)
               && (number_of_mobile_sprite == number_of_comparison_sprite));
    cls = (int'(number_of_comparison_sprite) < FIXED_BEGIN) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    clear_acc  = 1'b0;
    accum_en   = 1'b0;
    restart    = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start || start_pending) begin
          state_next = ACCUM;
          clear_acc  = 1'b1;
        end
      end
      ACCUM: begin
        // A restart beats both the update and frame_done of the same cycle.
        if (frame_start) begin
          clear_acc = 1'b1;
          restart   = 1'b1;
        end else begin
          accum_en = 1'b1;
          if (frame_done) state_next = COMMIT;
        end
      end
      COMMIT: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    acc_next = acc;
    cnt_next = cnt;
    if (clear_acc) begin
      acc_next = '0;
      cnt_next = '0;
    end else if (accum_en && hit) begin
      for (int i = 0; i < N_MOBILE; i++) begin
        if (number_of_mobile_sprite == SPRITE_BITS'(i))
          acc_next[2*i +: 2] = acc[2*i +: 2] | cls;
      end
      if (cnt != '1) cnt_next = cnt + COUNT_BITS'(1);
    end
  end

  always_comb begin
    irq_set = 1'b0;
    if (commit) begin
      for (int i = 0; i < N_MOBILE; i++) begin
        if (irq_mask[i] && (acc[2*i +: 2] != 2'b00)) irq_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc             <= '0;
      cnt             <= '0;
      start_pending   <= 1'b0;
      collision_flags <= '0;
      collision_count <= '0;
      flags_valid     <= 1'b0;
      frame_aborted   <= 1'b0;
      irq             <= 1'b0;
    end else begin
      acc           <= acc_next;
      cnt           <= cnt_next;
      // frame_start during COMMIT is remembered and acted on from IDLE.
      start_pending <= (state == COMMIT) && frame_start;
      if (commit) begin
        collision_flags <= acc;
        collision_count <= cnt;
        flags_valid     <= 1'b1;
        frame_aborted   <= 1'b0;
      end else if (restart) begin
        frame_aborted <= 1'b1;
      end
      if (irq_set)      irq <= 1'b1;
      else if (irq_ack) irq <= 1'b0;
    end
  end

  assign busy = (state == ACCUM);

endmodule

// File: tb/tb_collision_flag_bank.sv
module tb_collision_flag_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start, frame_done, update_valid, collision_result;
  logic [4:0]  number_of_mobile_sprite, number_of_comparison_sprite;
  logic [14:0] irq_mask;
  logic        irq_ack;
  logic [29:0] collision_flags;
  logic        flags_valid;
  logic [7:0]  collision_count;
  logic        frame_aborted, busy, irq;

  int n_cmp = 0;
  int n_err = 0;

  collision_flag_bank dut (
    .clk                         (clk),
    .reset                       (reset),
    .frame_start                 (frame_start),
    .frame_done                  (frame_done),
    .update_valid                (update_valid),
    .collision_result            (collision_result),
    .number_of_mobile_sprite     (number_of_mobile_sprite),
    .number_of_comparison_sprite (number_of_comparison_sprite),
    .irq_mask                    (irq_mask),
    .irq_ack                     (irq_ack),
    .collision_flags             (collision_flags),
    .flags_valid                 (flags_valid),
    .collision_count             (collision_count),
    .frame_aborted               (frame_aborted),
    .busy                        (busy),
    .irq                         (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  m;
    logic [4:0]  c;
    logic        r;
    logic [29:0] ef;
    logic [7:0]  ec;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic upd(input logic [4:0] m, input logic [4:0] c, input logic r);
    update_valid = 1'b1;
    number_of_mobile_sprite = m;
    number_of_comparison_sprite = c;
    collision_result = r;
    tick();
    update_valid = 1'b0;
    collision_result = 1'b0;
  endtask

  task automatic end_frame(input logic ack);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    irq_ack = ack;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    vecs[0] = '{5'd3,  5'd7,  1'b1, 30'h0000_0040, 8'd1};
    vecs[1] = '{5'd0,  5'd15, 1'b1, 30'h0000_0002, 8'd1};
    vecs[2] = '{5'd14, 5'd31, 1'b1, 30'h2000_0000, 8'd1};
    vecs[3] = '{5'd15, 5'd3,  1'b1, 30'h0000_0000, 8'd0};
    vecs[4] = '{5'd4,  5'd4,  1'b1, 30'h0000_0000, 8'd0};
    vecs[5] = '{5'd5,  5'd1,  1'b0, 30'h0000_0000, 8'd0};
    vecs[6] = '{5'd14, 5'd14, 1'b1, 30'h0000_0000, 8'd0};
    vecs[7] = '{5'd1,  5'd14, 1'b1, 30'h0000_0004, 8'd1};
    vecs[8] = '{5'd31, 5'd0,  1'b1, 30'h0000_0000, 8'd0};
    vecs[9] = '{5'd7,  5'd0,  1'b1, 30'h0000_4000, 8'd1};

    reset = 1'b0;
    frame_start = 0; frame_done = 0; update_valid = 0; collision_result = 0;
    number_of_mobile_sprite = 0; number_of_comparison_sprite = 0;
    irq_mask = '0; irq_ack = 0;
    #12;
    chk("reset_flags", 32'(collision_flags), 32'h0);
    chk("reset_count", 32'(collision_count), 32'h0);
    chk("reset_valid", 32'(flags_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_abort", 32'(frame_aborted), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      start_frame();
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'h1);
      upd(vecs[i].m, vecs[i].c, vecs[i].r);
      end_frame(1'b0);
      chk($sformatf("vec%0d_flags", i), 32'(collision_flags), 32'(vecs[i].ef));
      chk($sformatf("vec%0d_count", i), 32'(collision_count), 32'(vecs[i].ec));
      chk($sformatf("vec%0d_valid", i), 32'(flags_valid), 32'h1);
      chk($sformatf("vec%0d_idle", i), 32'(busy), 32'h0);
    end

    // OR merge within one pass; last update coincides with frame_done.
    start_frame();
    upd(5'd2, 5'd9, 1'b1);
    chk("hold_flags", 32'(collision_flags), 32'h4000);
    upd(5'd2, 5'd20, 1'b1);
    update_valid = 1'b1; collision_result = 1'b1;
    number_of_mobile_sprite = 5'd2; number_of_comparison_sprite = 5'd5;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0; update_valid = 1'b0; collision_result = 1'b0;
    tick();
    chk("merge_flags", 32'(collision_flags), 32'h30);
    chk("merge_count", 32'(collision_count), 32'd3);

    // Counter saturation.
    start_frame();
    update_valid = 1'b1; collision_result = 1'b1;
    number_of_mobile_sprite = 5'd0; number_of_comparison_sprite = 5'd1;
    for (int i = 0; i < 300; i++) tick();
    update_valid = 1'b0; collision_result = 1'b0;
    end_frame(1'b0);
    chk("sat_count", 32'(collision_count), 32'd255);
    chk("sat_flags", 32'(collision_flags), 32'h1);

    // Restart beats update and frame_done in the same cycle.
    start_frame();
    frame_start = 1'b1; frame_done = 1'b1; update_valid = 1'b1; collision_result = 1'b1;
    number_of_mobile_sprite = 5'd9; number_of_comparison_sprite = 5'd20;
    tick();
    frame_start = 1'b0; frame_done = 1'b0; update_valid = 1'b0; collision_result = 1'b0;
    chk("abort_flag", 32'(frame_aborted), 32'h1);
    chk("abort_busy", 32'(busy), 32'h1);
    tick(); tick();
    chk("abort_nocommit_busy", 32'(busy), 32'h1);
    chk("abort_nocommit_count", 32'(collision_count), 32'd255);
    upd(5'd6, 5'd2, 1'b1);
    end_frame(1'b0);
    chk("after_abort_flags", 32'(collision_flags), 32'h1000);
    chk("after_abort_count", 32'(collision_count), 32'd1);
    chk("after_abort_clear", 32'(frame_aborted), 32'h0);

    // frame_start during COMMIT becomes pending and enters ACCUM from IDLE.
    start_frame();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("pending_idle", 32'(busy), 32'h0);
    tick();
    chk("pending_accum", 32'(busy), 32'h1);
    frame_done = 1'b1; tick(); frame_done = 1'b0; tick();

    // Interrupt masking, ack, and ack colliding with a setting commit.
    irq_mask = 15'h0001;
    start_frame(); upd(5'd1, 5'd3, 1'b1); end_frame(1'b0);
    chk("irq_masked", 32'(irq), 32'h0);
    start_frame(); upd(5'd0, 5'd3, 1'b1); end_frame(1'b0);
    chk("irq_set", 32'(irq), 32'h1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("irq_ack", 32'(irq), 32'h0);
    start_frame(); upd(5'd0, 5'd3, 1'b1); end_frame(1'b1);
    chk("irq_ack_vs_set", 32'(irq), 32'h1);

    // Async reset mid-pass discards the partial frame.
    start_frame();
    upd(5'd1, 5'd2, 1'b1); upd(5'd2, 5'd3, 1'b1);
    upd(5'd3, 5'd20, 1'b1); upd(5'd4, 5'd5, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_reset_flags", 32'(collision_flags), 32'h0);
    chk("mid_reset_count", 32'(collision_count), 32'h0);
    chk("mid_reset_valid", 32'(flags_valid), 32'h0);
    chk("mid_reset_busy", 32'(busy), 32'h0);
    chk("mid_reset_irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    start_frame(); upd(5'd8, 5'd16, 1'b1); end_frame(1'b0);
    chk("post_reset_flags", 32'(collision_flags), 32'h20000);
    chk("post_reset_count", 32'(collision_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
